// File: rtl/icd_pkg.sv
// Shared types and constants for the ICD SPI command sequencer.
// Header command codes, FSM states and the layout of the status byte.
package icd_pkg;

    typedef enum logic [1:0] {
        ICD_STATUS = 2'b00,
        ICD_WRITE  = 2'b01,
        ICD_READ   = 2'b10,
        ICD_RSVD   = 2'b11
    } icd_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADR0,
        ST_ADR1,
        ST_ADR2,
        ST_WDATA,
        ST_WBUS,
        ST_RBUS,
        ST_RDATA
    } icd_state_t;

    localparam int ICD_ADDR_BYTES       = 3;
    localparam int ICD_STAT_OVERRUN_BIT = 7;

    function automatic logic [7:0] icd_status_byte(input logic overrun);
        logic [7:0] s;
        s = 8'h00;
        s[ICD_STAT_OVERRUN_BIT] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/icd_spi_sequencer.sv
// Decodes ICD SPI frames (status / bus write / bus read) into single-beat
// requests on an 8-bit bus-master port and loads responses into the SPI TX buffer.
module icd_spi_sequencer
    import icd_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk6x,
    input  logic              resetn,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_hdr_en_i,
    input  logic              rx_db_en_i,
    output logic [7:0]        tx_byte_o,
    output logic              tx_en_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    input  logic [7:0]        bus_rdata_i,
    input  logic              bus_ack_i
);

    icd_state_t        state_q, state_nxt;
    icd_cmd_t          cmd_q, cmd_nxt;
    icd_cmd_t          pend_cmd_q, pend_cmd_nxt;
    logic              pend_vld_q, pend_vld_nxt;
    logic              ovr_q, ovr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        wdata_q, wdata_nxt;
    logic              req_q, req_nxt;
    logic              we_q, we_nxt;
    logic [7:0]        tx_byte_q, tx_byte_nxt;
    logic              tx_en_q, tx_en_nxt;

    logic              busy;
    logic              pend_any;
    logic              hdr_go;
    icd_cmd_t          hdr_cmd;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Replace address byte idx (0 = LSB) with b; bytes beyond the wire format are untouched.
    function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] a,
                                                    input int idx,
                                                    input logic [7:0] b);
        logic [ADDR_W-1:0] r;
        r = a;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((i / 8) == idx && idx < ICD_ADDR_BYTES) r[i] = b[i % 8];
        end
        return r;
    endfunction

    assign busy     = (state_q == ST_WBUS) || (state_q == ST_RBUS);
    assign pend_any = pend_vld_q || rx_hdr_en_i;

    always_comb begin
        state_nxt    = state_q;
        cmd_nxt      = cmd_q;
        pend_cmd_nxt = pend_cmd_q;
        pend_vld_nxt = pend_vld_q;
        ovr_nxt      = ovr_q;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        req_nxt      = req_q;
        we_nxt       = we_q;
        tx_byte_nxt  = tx_byte_q;
        tx_en_nxt    = 1'b0;
        hdr_go       = 1'b0;
        hdr_cmd      = ICD_STATUS;

        if (busy) begin
            // A request is outstanding: nothing aborts it, headers wait in the pending slot.
            if (rx_hdr_en_i) begin
                if (pend_vld_q) ovr_nxt = 1'b1;
                pend_vld_nxt = 1'b1;
                pend_cmd_nxt = icd_cmd_t'(rx_byte_i[7:6]);
            end
            if (rx_db_en_i) ovr_nxt = 1'b1;
            if (bus_ack_i && req_q) begin
                req_nxt  = 1'b0;
                addr_nxt = addr_q + ADDR_ONE;
                if (pend_any) begin
                    state_nxt = ST_IDLE;
                end else if (state_q == ST_WBUS) begin
                    state_nxt = ST_WDATA;
                end else begin
                    tx_byte_nxt = bus_rdata_i;
                    tx_en_nxt   = 1'b1;
                    state_nxt   = ST_RDATA;
                end
            end
        end else begin
            if (rx_hdr_en_i) begin
                hdr_go       = 1'b1;
                hdr_cmd      = icd_cmd_t'(rx_byte_i[7:6]);
                pend_vld_nxt = 1'b0;
            end else if (pend_vld_q) begin
                hdr_go       = 1'b1;
                hdr_cmd      = pend_cmd_q;
                pend_vld_nxt = 1'b0;
            end else if (rx_db_en_i) begin
                case (state_q)
                    ST_ADR0: begin
                        addr_nxt  = put_byte(addr_q, 0, rx_byte_i);
                        state_nxt = ST_ADR1;
                    end
                    ST_ADR1: begin
                        addr_nxt  = put_byte(addr_q, 1, rx_byte_i);
                        state_nxt = ST_ADR2;
                    end
                    ST_ADR2: begin
                        addr_nxt = put_byte(addr_q, 2, rx_byte_i);
                        if (cmd_q == ICD_WRITE) begin
                            state_nxt = ST_WDATA;
                        end else begin
                            req_nxt   = 1'b1;
                            we_nxt    = 1'b0;
                            state_nxt = ST_RBUS;
                        end
                    end
                    ST_WDATA: begin
                        wdata_nxt = rx_byte_i;
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b1;
                        state_nxt = ST_WBUS;
                    end
                    ST_RDATA: begin
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                        state_nxt = ST_RBUS;
                    end
                    default: ;
                endcase
            end

            if (hdr_go) begin
                case (hdr_cmd)
                    ICD_WRITE, ICD_READ: begin
                        cmd_nxt   = hdr_cmd;
                        state_nxt = ST_ADR0;
                    end
                    default: begin
                        tx_byte_nxt = icd_status_byte(ovr_q);
                        tx_en_nxt   = 1'b1;
                        ovr_nxt     = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cmd_q      <= ICD_STATUS;
            pend_cmd_q <= ICD_STATUS;
            pend_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cmd_q      <= cmd_nxt;
            pend_cmd_q <= pend_cmd_nxt;
            pend_vld_q <= pend_vld_nxt;
            ovr_q      <= ovr_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            req_q      <= req_nxt;
            we_q       <= we_nxt;
            tx_byte_q  <= tx_byte_nxt;
            tx_en_q    <= tx_en_nxt;
        end
    end

    assign tx_byte_o   = tx_byte_q;
    assign tx_en_o     = tx_en_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_icd_spi_sequencer.sv
// Self-checking bench for icd_spi_sequencer: table of SPI byte events with
// expected bus transfers and TX loads, scoreboarded by bus and TX monitors.
module tb_icd_spi_sequencer;

    logic        clk6x = 1'b0;
    logic        resetn;
    logic [7:0]  rx_byte;
    logic        rx_hdr_en;
    logic        rx_db_en;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        bus_req;
    logic        bus_we;
    logic [23:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    icd_spi_sequencer #(.ADDR_W(24)) dut (
        .clk6x      (clk6x),
        .resetn     (resetn),
        .rx_byte_i  (rx_byte),
        .rx_hdr_en_i(rx_hdr_en),
        .rx_db_en_i (rx_db_en),
        .tx_byte_o  (tx_byte),
        .tx_en_o    (tx_en),
        .bus_req_o  (bus_req),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack)
    );

    always #10 clk6x = ~clk6x;

    typedef struct {
        logic        hdr;
        logic [7:0]  b;
        int          ack_dly;
        logic        tx_v;
        logic [7:0]  tx;
        logic        bus_v;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wd;
    } bexp_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          ack_delay = 3;
    int          req_rises = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rd_q[$];
    bexp_t       bus_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic hdr, input logic [7:0] b, input int gap);
        @(negedge clk6x);
        rx_byte   = b;
        rx_hdr_en = hdr;
        rx_db_en  = !hdr;
        @(negedge clk6x);
        rx_hdr_en = 1'b0;
        rx_db_en  = 1'b0;
        repeat (gap) @(negedge clk6x);
    endtask

    task automatic exp_bus(input logic we, input logic [23:0] addr, input logic [7:0] wd);
        bexp_t e;
        e.we = we; e.addr = addr; e.wd = wd;
        bus_q.push_back(e);
    endtask

    // Bus slave: ack a held request after ack_delay cycles, rdata from rd_q.
    initial begin
        int cnt;
        cnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk6x);
            if (bus_ack) begin
                bus_ack = 1'b0;
                cnt = 0;
            end else if (bus_req) begin
                if (cnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Bus monitor: compare each new request, and its stability until it drops.
    initial begin
        logic        prev;
        logic        stable;
        logic [32:0] snap;
        bexp_t       e;
        prev = 1'b0;
        stable = 1'b1;
        snap = '0;
        forever begin
            @(negedge clk6x);
            if (bus_req && !prev) begin
                req_rises++;
                snap = {bus_we, bus_addr, bus_wdata};
                stable = 1'b1;
                if (bus_q.size() == 0) begin
                    check("unexpected_req", {7'd0, bus_we, bus_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = bus_q.pop_front();
                    if (e.we) check("bus_write", {bus_we, bus_addr, bus_wdata}, {e.we, e.addr, e.wd});
                    else      check("bus_read", {7'd0, bus_we, bus_addr}, {7'd0, e.we, e.addr});
                end
            end else if (bus_req && prev) begin
                if ({bus_we, bus_addr, bus_wdata} !== snap) stable = 1'b0;
            end else if (!bus_req && prev) begin
                check("bus_stable", {31'd0, stable}, 32'd1);
            end
            prev = bus_req;
        end
    end

    // TX monitor: every tx_en pulse must match the next expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk6x);
            if (tx_en) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx", {24'd0, tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", {24'd0, tx_byte}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    vec_t tbl[13];

    initial begin
        int r0;
        tbl[0]  = '{1'b1, 8'h00, 3, 1'b1, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h7F, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'h34, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'h12, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 8'hAA, 3, 1'b0, 8'h00, 1'b1, 1'b1, 24'h001234, 8'hAA, 8'h00};
        tbl[6]  = '{1'b0, 8'hBB, 3, 1'b0, 8'h00, 1'b1, 1'b1, 24'h001235, 8'hBB, 8'h00};
        tbl[7]  = '{1'b1, 8'hBF, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 8'hFF, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 8'hFF, 3, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 8'hFF, 3, 1'b1, 8'h5A, 1'b1, 1'b0, 24'hFFFFFF, 8'h00, 8'h5A};
        tbl[11] = '{1'b0, 8'h00, 3, 1'b1, 8'hC3, 1'b1, 1'b0, 24'h000000, 8'h00, 8'hC3};
        tbl[12] = '{1'b1, 8'hC5, 3, 1'b1, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00, 8'h00};

        resetn = 1'b0;
        rx_byte = 8'h00;
        rx_hdr_en = 1'b0;
        rx_db_en = 1'b0;
        repeat (4) @(negedge clk6x);
        resetn = 1'b1;
        @(negedge clk6x);

        check("rst_tx_byte", {24'd0, tx_byte}, 32'h0);
        check("rst_tx_en", {31'd0, tx_en}, 32'h0);
        check("rst_req", {31'd0, bus_req}, 32'h0);
        check("rst_we", {31'd0, bus_we}, 32'h0);
        check("rst_addr", {8'd0, bus_addr}, 32'h0);
        check("rst_wdata", {24'd0, bus_wdata}, 32'h0);

        // STATUS response lands exactly one cycle after the header strobe.
        tx_q.push_back(8'h00);
        rx_byte = 8'h00;
        rx_hdr_en = 1'b1;
        @(negedge clk6x);
        rx_hdr_en = 1'b0;
        check("status_tx_en_t1", {31'd0, tx_en}, 32'd1);
        @(negedge clk6x);
        check("status_tx_en_t2", {31'd0, tx_en}, 32'd0);
        check("status_bus_idle", {bus_req, bus_we, bus_addr}, 32'h0);
        repeat (4) @(negedge clk6x);

        r0 = req_rises;
        for (int i = 0; i < 13; i++) begin
            ack_delay = tbl[i].ack_dly;
            if (tbl[i].bus_v) begin
                exp_bus(tbl[i].we, tbl[i].addr, tbl[i].wd);
                if (!tbl[i].we) rd_q.push_back(tbl[i].rd);
            end
            if (tbl[i].tx_v) tx_q.push_back(tbl[i].tx);
            send(tbl[i].hdr, tbl[i].b, 24);
        end
        check("table_req_count", req_rises - r0, 32'd4);

        // Data byte while a write is outstanding: dropped, overrun latched.
        ack_delay = 20;
        r0 = req_rises;
        send(1'b1, 8'h40, 4);
        send(1'b0, 8'h00, 4);
        send(1'b0, 8'h00, 4);
        send(1'b0, 8'h10, 4);
        exp_bus(1'b1, 24'h100000, 8'h11);
        send(1'b0, 8'h11, 3);
        send(1'b0, 8'h99, 40);
        check("ovr_req_count", req_rises - r0, 32'd1);
        check("ovr_addr_inc", {8'd0, bus_addr}, 32'h100001);
        check("ovr_wdata_kept", {24'd0, bus_wdata}, 32'h11);
        ack_delay = 3;
        tx_q.push_back(8'h80);
        send(1'b1, 8'h00, 8);
        tx_q.push_back(8'h00);
        send(1'b1, 8'h00, 8);

        // Header during a read: no read-data load, the pending READ takes the new address.
        send(1'b1, 8'h80, 4);
        send(1'b0, 8'h56, 4);
        send(1'b0, 8'h34, 4);
        ack_delay = 20;
        exp_bus(1'b0, 24'h123456, 8'h00);
        rd_q.push_back(8'h77);
        send(1'b0, 8'h12, 3);
        send(1'b1, 8'h80, 40);
        ack_delay = 3;
        send(1'b0, 8'h01, 4);
        send(1'b0, 8'h00, 4);
        exp_bus(1'b0, 24'h000001, 8'h00);
        rd_q.push_back(8'h44);
        tx_q.push_back(8'h44);
        send(1'b0, 8'h00, 24);

        // Second header replaces the pending one and raises overrun.
        send(1'b1, 8'h80, 4);
        send(1'b0, 8'h00, 4);
        send(1'b0, 8'h02, 4);
        ack_delay = 20;
        exp_bus(1'b0, 24'h000200, 8'h00);
        rd_q.push_back(8'h66);
        send(1'b0, 8'h00, 3);
        send(1'b1, 8'h80, 3);
        tx_q.push_back(8'h80);
        send(1'b1, 8'h00, 40);
        ack_delay = 3;
        tx_q.push_back(8'h00);
        send(1'b1, 8'h00, 8);

        // Reset while a read is outstanding.
        ack_delay = 1000;
        send(1'b1, 8'h80, 4);
        send(1'b0, 8'h10, 4);
        send(1'b0, 8'h00, 4);
        exp_bus(1'b0, 24'h000010, 8'h00);
        send(1'b0, 8'h00, 3);
        send(1'b0, 8'h55, 2);
        check("req_before_reset", {31'd0, bus_req}, 32'd1);
        @(negedge clk6x);
        resetn = 1'b0;
        @(posedge clk6x);
        #1;
        check("reset_req_drop", {31'd0, bus_req}, 32'd0);
        check("reset_addr", {8'd0, bus_addr}, 32'h0);
        check("reset_tx_en", {31'd0, tx_en}, 32'd0);
        @(negedge clk6x);
        resetn = 1'b1;
        ack_delay = 3;
        tx_q.push_back(8'h00);
        send(1'b1, 8'h00, 8);

        check("tx_q_drained", tx_q.size(), 32'd0);
        check("bus_q_drained", bus_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
